datapath_core: RTL and testbench

//  Processor datapath driven cycle-by-cycle by the control FSM: general registers R0..R6, PC, IR, A, G,

---
 rtl/datapath_core.sv | 118 +++++++++++
 tb/tb_datapath_core.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/datapath_core.sv
// Processor datapath: R0..R6, PC, IR, A, G, ADDR, DOUT around one shared bus, plus the ALU.
// Every register is updated on the rising edge; the bus and the ALU result are combinational.
module datapath_core #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              IR_in,
  input  logic              ADDR_in,
  input  logic              DOUT_in,
  input  logic              W_D,
  input  logic              A_in,
  input  logic              G_in,
  input  logic              incr_PC,
  input  logic              PC_in,
  input  logic [1:0]        mux_control,
  input  logic [2:0]        ULA_control,
  input  logic [6:0]        register_in,
  input  logic [2:0]        register_out,
  output logic [IR_W-1:0]   IR,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              mem_wr,
  output logic              g_nz,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0] r_regs [0:6];
  logic [DATA_W-1:0] r_pc;
  logic [IR_W-1:0]   r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic              r_mem_wr;

  logic [DATA_W-1:0] w_reg_rd;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_alu;

  // Index 7 of the read port aliases the PC so MOV can copy it into a general register.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_reg_rd = r_pc;
    case (register_out)
      3'd0:    w_reg_rd = r_regs[0];
      3'd1:    w_reg_rd = r_regs[1];
      3'd2:    w_reg_rd = r_regs[2];
      3'd3:    w_reg_rd = r_regs[3];
      3'd4:    w_reg_rd = r_regs[4];
      3'd5:    w_reg_rd = r_regs[5];
      3'd6:    w_reg_rd = r_regs[6];
      default: w_reg_rd = r_pc;
    endcase
  end

  always_comb begin
    w_bus = DIN;
    case (mux_control)
      2'b00:   w_bus = DIN;
      2'b01:   w_bus = w_reg_rd;
      2'b10:   w_bus = r_pc;
      default: w_bus = r_g;
    endcase
  end

  // Shifts use only the low four bus bits; carry and borrow fall off the top.
  always_comb begin
    w_alu = w_bus;
    case (ULA_control)
      3'b000:  w_alu = r_a + w_bus;
      3'b001:  w_alu = r_a - w_bus;
      3'b010:  w_alu = r_a | w_bus;
      3'b011:  w_alu = ($signed(r_a) < $signed(w_bus)) ? DATA_W'(1) : '0;
      3'b100:  w_alu = r_a << w_bus[3:0];
      3'b101:  w_alu = r_a >> w_bus[3:0];
      default: w_alu = w_bus;
    endcase
  end

  // NOTE: state uses non-blocking assignments, so G_in and A_in in the same cycle see the old A,
  // and a register read and written together drives its old value on the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the register file is reset element by element because software relies on R0..R6 starting at zero.
      for (int k = 0; k < 7; k++) r_regs[k] <= '0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_g      <= '0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_mem_wr <= 1'b0;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (register_in[k]) r_regs[k] <= w_bus;
      end
      if (PC_in)        r_pc <= w_bus;
      else if (incr_PC) r_pc <= r_pc + DATA_W'(1);
      if (IR_in)   r_ir   <= DIN[IR_W-1:0];
      if (A_in)    r_a    <= w_bus;
      if (G_in)    r_g    <= w_alu;
      if (ADDR_in) r_addr <= w_bus;
      if (DOUT_in) r_dout <= w_bus;
      r_mem_wr <= W_D;
    end
  end

  assign IR     = r_ir;
  assign addr   = r_addr;
  assign dout   = r_dout;
  assign mem_wr = r_mem_wr;
  assign g_nz   = |r_g;
  assign bus    = w_bus;

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: per-cycle vector table plus hand-written reset sequences.
// The bus is compared before the edge; registered outputs are compared just after it.
module tb_datapath_core;

  localparam int DATA_W = 16;
  localparam int IR_W   = 10;

  localparam logic [7:0] C_IR   = 8'h80;
  localparam logic [7:0] C_ADDR = 8'h40;
  localparam logic [7:0] C_DOUT = 8'h20;
  localparam logic [7:0] C_WD   = 8'h10;
  localparam logic [7:0] C_A    = 8'h08;
  localparam logic [7:0] C_G    = 8'h04;
  localparam logic [7:0] C_INC  = 8'h02;
  localparam logic [7:0] C_PC   = 8'h01;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [1:0]        mux;
    logic [2:0]        rout;
    logic [6:0]        rin;
    logic [2:0]        ula;
    logic [7:0]        ctl;
    logic [DATA_W-1:0] e_bus;
    logic [IR_W-1:0]   e_ir;
    logic [DATA_W-1:0] e_addr;
    logic [DATA_W-1:0] e_dout;
    logic              e_mw;
    logic              e_gnz;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] DIN;
  logic              IR_in, ADDR_in, DOUT_in, W_D, A_in, G_in, incr_PC, PC_in;
  logic [1:0]        mux_control;
  logic [2:0]        ULA_control;
  logic [6:0]        register_in;
  logic [2:0]        register_out;
  logic [IR_W-1:0]   IR;
  logic [DATA_W-1:0] addr, dout, bus;
  logic              mem_wr, g_nz;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  datapath_core #(.DATA_W(DATA_W), .IR_W(IR_W)) dut (
    .clock(clock), .reset(reset), .DIN(DIN),
    .IR_in(IR_in), .ADDR_in(ADDR_in), .DOUT_in(DOUT_in), .W_D(W_D),
    .A_in(A_in), .G_in(G_in), .incr_PC(incr_PC), .PC_in(PC_in),
    .mux_control(mux_control), .ULA_control(ULA_control),
    .register_in(register_in), .register_out(register_out),
    .IR(IR), .addr(addr), .dout(dout), .mem_wr(mem_wr), .g_nz(g_nz), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [DATA_W-1:0] din, input logic [1:0] mux, input logic [2:0] rout,
                       input logic [6:0] rin, input logic [2:0] ula, input logic [7:0] ctl);
    DIN = din; mux_control = mux; register_out = rout; register_in = rin; ULA_control = ula;
    {IR_in, ADDR_in, DOUT_in, W_D, A_in, G_in, incr_PC, PC_in} = ctl;
  endtask

  task automatic add(input logic [DATA_W-1:0] din, input logic [1:0] mux, input logic [2:0] rout,
                     input logic [6:0] rin, input logic [2:0] ula, input logic [7:0] ctl,
                     input logic [DATA_W-1:0] e_bus, input logic [IR_W-1:0] e_ir,
                     input logic [DATA_W-1:0] e_addr, input logic [DATA_W-1:0] e_dout,
                     input logic e_mw, input logic e_gnz);
    vec_t v;
    v.din = din; v.mux = mux; v.rout = rout; v.rin = rin; v.ula = ula; v.ctl = ctl;
    v.e_bus = e_bus; v.e_ir = e_ir; v.e_addr = e_addr; v.e_dout = e_dout;
    v.e_mw = e_mw; v.e_gnz = e_gnz;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive, compare the bus, clock once, compare registered outputs.
  task automatic apply(input vec_t v, input int idx);
    drive(v.din, v.mux, v.rout, v.rin, v.ula, v.ctl);
    #1 check($sformatf("v%0d bus", idx), 32'(bus), 32'(v.e_bus));
    @(posedge clock); #1;
    check($sformatf("v%0d IR", idx), 32'(IR), 32'(v.e_ir));
    check($sformatf("v%0d addr", idx), 32'(addr), 32'(v.e_addr));
    check($sformatf("v%0d dout", idx), 32'(dout), 32'(v.e_dout));
    check($sformatf("v%0d mem_wr", idx), 32'(mem_wr), 32'(v.e_mw));
    check($sformatf("v%0d g_nz", idx), 32'(g_nz), 32'(v.e_gnz));
    @(negedge clock);
  endtask

  // Reset with every enable raised; afterwards every output and every bus source must read zero.
  task automatic reset_and_verify(input string tag);
    reset = 1'b1;
    drive(16'hFFFF, 2'b00, 3'd0, 7'h7F, 3'b000, 8'hFF);
    @(posedge clock); #1;
    check({tag, " IR"}, 32'(IR), 32'h0);
    check({tag, " addr"}, 32'(addr), 32'h0);
    check({tag, " dout"}, 32'(dout), 32'h0);
    check({tag, " mem_wr"}, 32'(mem_wr), 32'h0);
    check({tag, " g_nz"}, 32'(g_nz), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(16'h0000, 2'b01, 3'd0, 7'h00, 3'b000, 8'h00);
    for (int r = 0; r < 8; r++) begin
      register_out = 3'(r);
      #1 check($sformatf("%s reg%0d", tag, r), 32'(bus), 32'h0);
    end
    mux_control = 2'b10;
    #1 check({tag, " PC"}, 32'(bus), 32'h0);
    mux_control = 2'b11;
    #1 check({tag, " G"}, 32'(bus), 32'h0);
    @(negedge clock);
  endtask

  initial begin
    //   din     mux rout rin    ula     ctl            bus      ir      addr     dout     mw gnz
    add(16'h0005, 0, 0, 7'h02, 3'd0, 8'h00,          16'h0005, 10'h0, 16'h0, 16'h0, 0, 0); // MVI R1,5
    add(16'h0000, 1, 1, 7'h08, 3'd0, 8'h00,          16'h0005, 10'h0, 16'h0, 16'h0, 0, 0); // MV R3,R1
    add(16'h0000, 1, 3, 7'h00, 3'd0, 8'h00,          16'h0005, 10'h0, 16'h0, 16'h0, 0, 0);
    add(16'h0003, 0, 0, 7'h01, 3'd0, 8'h00,          16'h0003, 10'h0, 16'h0, 16'h0, 0, 0); // R0=3
    add(16'hFFFF, 0, 0, 7'h02, 3'd0, 8'h00,          16'hFFFF, 10'h0, 16'h0, 16'h0, 0, 0); // R1=FFFF
    add(16'h0000, 1, 0, 7'h00, 3'd0, C_A,            16'h0003, 10'h0, 16'h0, 16'h0, 0, 0); // A=R0
    add(16'h0000, 1, 1, 7'h00, 3'd0, C_G,            16'hFFFF, 10'h0, 16'h0, 16'h0, 0, 1); // G=3+FFFF=2
    add(16'h0000, 3, 0, 7'h04, 3'd0, 8'h00,          16'h0002, 10'h0, 16'h0, 16'h0, 0, 1); // R2=G
    add(16'h0000, 1, 2, 7'h00, 3'd0, 8'h00,          16'h0002, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h0000, 0, 0, 7'h00, 3'd0, C_A,            16'h0000, 10'h0, 16'h0, 16'h0, 0, 1); // A=0
    add(16'h0001, 0, 0, 7'h00, 3'd1, C_G,            16'h0001, 10'h0, 16'h0, 16'h0, 0, 1); // G=0-1
    add(16'h0000, 3, 0, 7'h00, 3'd0, 8'h00,          16'hFFFF, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h0000, 0, 0, 7'h00, 3'd0, C_G,            16'h0000, 10'h0, 16'h0, 16'h0, 0, 0); // G=0
    add(16'hFFFF, 0, 0, 7'h00, 3'd0, C_A,            16'hFFFF, 10'h0, 16'h0, 16'h0, 0, 0); // A=-1
    add(16'h0001, 0, 0, 7'h00, 3'd3, C_G,            16'h0001, 10'h0, 16'h0, 16'h0, 0, 1); // -1<1
    add(16'h0000, 3, 0, 7'h00, 3'd0, 8'h00,          16'h0001, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'hFFFE, 0, 0, 7'h00, 3'd3, C_G,            16'hFFFE, 10'h0, 16'h0, 16'h0, 0, 0); // -1<-2 no
    add(16'h0001, 0, 0, 7'h00, 3'd3, C_G | C_A,      16'h0001, 10'h0, 16'h0, 16'h0, 0, 1); // old A used
    add(16'h0013, 0, 0, 7'h00, 3'd4, C_G,            16'h0013, 10'h0, 16'h0, 16'h0, 0, 1); // 1<<3
    add(16'h0000, 3, 0, 7'h00, 3'd0, 8'h00,          16'h0008, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h8000, 0, 0, 7'h00, 3'd0, C_A,            16'h8000, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h000F, 0, 0, 7'h00, 3'd5, C_G,            16'h000F, 10'h0, 16'h0, 16'h0, 0, 1); // logical >>15
    add(16'h0000, 3, 0, 7'h00, 3'd0, 8'h00,          16'h0001, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h00F0, 0, 0, 7'h00, 3'd2, C_G,            16'h00F0, 10'h0, 16'h0, 16'h0, 0, 1); // OR
    add(16'h0000, 3, 0, 7'h00, 3'd0, 8'h00,          16'h80F0, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h1234, 0, 0, 7'h00, 3'd6, C_G,            16'h1234, 10'h0, 16'h0, 16'h0, 0, 1); // pass
    add(16'h5678, 0, 0, 7'h00, 3'd7, C_G,            16'h5678, 10'h0, 16'h0, 16'h0, 0, 1); // pass
    add(16'h0000, 3, 0, 7'h00, 3'd0, 8'h00,          16'h5678, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'hABCD, 0, 0, 7'h70, 3'd0, 8'h00,          16'hABCD, 10'h0, 16'h0, 16'h0, 0, 1); // R4..R6
    add(16'h0000, 1, 4, 7'h00, 3'd0, 8'h00,          16'hABCD, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h0000, 1, 6, 7'h00, 3'd0, 8'h00,          16'hABCD, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h0000, 1, 5, 7'h01, 3'd0, 8'h00,          16'hABCD, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'hFFFF, 0, 0, 7'h00, 3'd0, C_PC,           16'hFFFF, 10'h0, 16'h0, 16'h0, 0, 1); // PC=FFFF
    add(16'h0000, 2, 0, 7'h00, 3'd0, C_INC,          16'hFFFF, 10'h0, 16'h0, 16'h0, 0, 1); // wrap
    add(16'h0000, 2, 0, 7'h00, 3'd0, 8'h00,          16'h0000, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'h0040, 0, 0, 7'h00, 3'd0, C_PC | C_INC,   16'h0040, 10'h0, 16'h0, 16'h0, 0, 1); // PC_in wins
    add(16'h0000, 1, 7, 7'h00, 3'd0, C_INC,          16'h0040, 10'h0, 16'h0, 16'h0, 0, 1); // rout 7 = PC
    add(16'h0000, 2, 0, 7'h00, 3'd0, 8'h00,          16'h0041, 10'h0, 16'h0, 16'h0, 0, 1);
    add(16'hFFFF, 0, 0, 7'h00, 3'd0, C_IR,           16'hFFFF, 10'h3FF, 16'h0, 16'h0, 0, 1);
    add(16'h0155, 0, 0, 7'h00, 3'd0, 8'h00,          16'h0155, 10'h3FF, 16'h0, 16'h0, 0, 1); // IR holds
    add(16'h0010, 0, 0, 7'h00, 3'd0, C_ADDR,         16'h0010, 10'h3FF, 16'h0010, 16'h0, 0, 1);
    add(16'h00AA, 0, 0, 7'h00, 3'd0, C_DOUT | C_WD,  16'h00AA, 10'h3FF, 16'h0010, 16'h00AA, 1, 1);
    add(16'h0000, 0, 0, 7'h00, 3'd0, 8'h00,          16'h0000, 10'h3FF, 16'h0010, 16'h00AA, 0, 1);
    add(16'h0000, 0, 0, 7'h00, 3'd0, C_WD,           16'h0000, 10'h3FF, 16'h0010, 16'h00AA, 1, 1);

    @(negedge clock);
    reset_and_verify("rst0");

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset lands mid-instruction while a write strobe is still pending and state is nonzero.
    reset_and_verify("rst1");

    // After reset, increment starts the PC from zero.
    drive(16'h0000, 2'b10, 3'd0, 7'h00, 3'b000, C_INC);
    @(posedge clock); #1;
    check("pc after rst", 32'(bus), 32'h0001);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
